tow_match_scorer: RTL and testbench

- Parametrised next-generation tug-of-war scorer. Tracks the rope position over 2*STEPS+1 visible positions, applies per-position bonus double-steps and jump-the-light penalties, and detects round wins.
- Accumulates round wins per side into a best-of match, with a sticky match-over result.
- Sits between the push arbiter (right/winrnd/leds_on) and the LED bar / round sequencer.

---
 rtl/tow_match_scorer.sv | 140 ++++++++++++++
 tb/tb_tow_match_scorer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tow_match_scorer.sv
// Tug-of-war round and match scorer: rope position, bonus/penalty steps, round and match wins.
// Optional build macro TOW_CATCHUP_EN: a trailing player's proper push always moves two steps.
module tow_match_scorer #(
  parameter int STEPS      = 3,
  parameter int MATCH_WINS = 2,
  parameter int CNT_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               right,
  input  logic               leds_on,
  input  logic               winrnd,
  input  logic               next_round,
  input  logic [2*STEPS:0]   bonus_in,
  output logic [2*STEPS:0]   score,
  output logic [CNT_W-1:0]   wins_l,
  output logic [CNT_W-1:0]   wins_r,
  output logic               round_done,
  output logic               match_over,
  output logic               match_right
);

  localparam int BW = 2*STEPS + 1;
  localparam int PW = $clog2(2*STEPS + 3);
  localparam logic [PW-1:0] POS_WR = '0;
  localparam logic [PW-1:0] POS_N  = PW'(STEPS + 1);
  localparam logic [PW-1:0] POS_WL = PW'(2*STEPS + 2);

  typedef enum logic [1:0] {PLAY, ROUND_WON, MATCH_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [PW-1:0]    r_pos;
  logic [BW-1:0]    r_bonus_q;
  logic [CNT_W-1:0] r_wins_l, r_wins_r;
  logic             r_round_done, r_match_over, r_match_right;

  logic             w_mr, w_dbl, w_win, w_winner_right, w_match_win;
  logic [PW:0]      w_pos_ext, w_step, w_sum;
  logic [PW-1:0]    w_next_pos;
  logic [CNT_W-1:0] w_wins_l_inc, w_wins_r_inc;
  logic             w_move, w_restart, w_load_bonus;
  logic [BW-1:0]    w_score;

  // mr: the rope moves toward the right player's win end (position decreases).
  assign w_mr      = (right & leds_on) | (~right & ~leds_on);
  assign w_pos_ext = {1'b0, r_pos};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_dbl = 1'b0;
    if (leds_on) begin
      for (int p = 1; p <= BW; p++)
        if (r_pos == PW'(p) && r_bonus_q[p-1]) w_dbl = 1'b1;
`ifdef TOW_CATCHUP_EN
      if (w_mr && w_pos_ext >= (PW+1)'(STEPS + 3)) w_dbl = 1'b1;
      if (!w_mr && (w_pos_ext + (PW+1)'(2)) <= (PW+1)'(STEPS + 1)) w_dbl = 1'b1;
`endif
    end
  end

  assign w_step = w_dbl ? (PW+1)'(2) : (PW+1)'(1);
  assign w_sum  = w_pos_ext + w_step;

  always_comb begin
    w_next_pos = r_pos;
    if (w_mr) begin
      if (w_pos_ext < w_step) w_next_pos = POS_WR;
      else                    w_next_pos = PW'(w_pos_ext - w_step);
    end else begin
      if (w_sum > {1'b0, POS_WL}) w_next_pos = POS_WL;
      else                        w_next_pos = PW'(w_sum);
    end
  end

  assign w_win          = (w_next_pos == POS_WR) || (w_next_pos == POS_WL);
  assign w_winner_right = (w_next_pos == POS_WR);
  assign w_wins_l_inc   = r_wins_l + CNT_W'(1);
  assign w_wins_r_inc   = r_wins_r + CNT_W'(1);
  assign w_match_win    = w_winner_right ? (w_wins_r_inc == CNT_W'(MATCH_WINS))
                                         : (w_wins_l_inc == CNT_W'(MATCH_WINS));

  always_ff @(posedge clk) begin
    if (rst) r_state <= PLAY;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PLAY:       if (winrnd && w_win) w_state_next = w_match_win ? MATCH_DONE : ROUND_WON;
      ROUND_WON:  if (next_round) w_state_next = PLAY;
      MATCH_DONE: w_state_next = MATCH_DONE;
      default:    w_state_next = PLAY;
    endcase
  end

  always_comb begin
    w_move       = (r_state == PLAY) && winrnd;
    w_restart    = (r_state == ROUND_WON) && next_round;
    w_load_bonus = (r_state == PLAY) && (r_pos == POS_N);
    for (int i = 0; i < BW; i++) w_score[i] = ((BW - 1 - i) % 2) == 0;
    if (r_pos >= PW'(1) && r_pos <= PW'(BW)) w_score = BW'(1) << (r_pos - PW'(1));
    else if (r_pos == POS_WL)                w_score = {{STEPS{1'b1}}, {(STEPS+1){1'b0}}};
    else if (r_pos == POS_WR)                w_score = {{(STEPS+1){1'b0}}, {STEPS{1'b1}}};
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos         <= POS_N;
      r_bonus_q     <= '0;
      r_wins_l      <= '0;
      r_wins_r      <= '0;
      r_round_done  <= 1'b0;
      r_match_over  <= 1'b0;
      r_match_right <= 1'b0;
    end else begin
      r_round_done <= w_move && w_win;
      if (w_load_bonus) r_bonus_q <= bonus_in;
      if (w_move)         r_pos <= w_next_pos;
      else if (w_restart) r_pos <= POS_N;
      if (w_move && w_win) begin
        if (w_winner_right) r_wins_r <= w_wins_r_inc;
        else                r_wins_l <= w_wins_l_inc;
        if (w_match_win) begin
          r_match_over  <= 1'b1;
          r_match_right <= w_winner_right;
        end
      end
    end
  end

  assign score       = w_score;
  assign wins_l      = r_wins_l;
  assign wins_r      = r_wins_r;
  assign round_done  = r_round_done;
  assign match_over  = r_match_over;
  assign match_right = r_match_right;

endmodule

// File: tb/tb_tow_match_scorer.sv
// Self-checking bench for tow_match_scorer: directed game scenarios, then random play
// compared against an integer-position reference model.
module tb_tow_match_scorer;

  localparam int STEPS = 3;
  localparam int MW    = 2;
  localparam int BW    = 2*STEPS + 1;
  localparam int N     = STEPS + 1;
  localparam int WL    = 2*STEPS + 2;

  logic          clk = 1'b0;
  logic          rst, right, leds_on, winrnd, next_round;
  logic [BW-1:0] bonus_in;
  logic [BW-1:0] score;
  logic [1:0]    wins_l, wins_r;
  logic          round_done, match_over, match_right;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain integers for the rope and scores.
  int       m_pos, m_wl, m_wr;
  bit       m_between, m_over, m_right, m_done;
  bit [BW-1:0] m_bonus;

  tow_match_scorer #(.STEPS(STEPS), .MATCH_WINS(MW), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .right(right), .leds_on(leds_on), .winrnd(winrnd),
    .next_round(next_round), .bonus_in(bonus_in), .score(score), .wins_l(wins_l),
    .wins_r(wins_r), .round_done(round_done), .match_over(match_over),
    .match_right(match_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] bar(input int p);
    if (p == 0)  return BW'(7);
    if (p == WL) return BW'(7 << 4);
    return BW'(1 << (p - 1));
  endfunction

  task automatic model_step();
    int  step, np;
    bit  toward_r, trailing;
    if (rst) begin
      m_pos = N; m_bonus = '0; m_wl = 0; m_wr = 0;
      m_between = 0; m_over = 0; m_right = 0; m_done = 0;
      return;
    end
    m_done = 0;
    if (m_over) return;
    if (m_between) begin
      if (next_round) begin m_pos = N; m_between = 0; end
      return;
    end
    if (winrnd) begin
      toward_r = (right == leds_on);
      step = 1;
      if (leds_on) begin
        if (m_bonus[m_pos-1]) step = 2;
`ifdef TOW_CATCHUP_EN
        trailing = toward_r ? (m_pos - N >= 2) : (N - m_pos >= 2);
        if (trailing) step = 2;
`else
        trailing = 0;
`endif
      end
      np = toward_r ? m_pos - step : m_pos + step;
      if (np < 0)  np = 0;
      if (np > WL) np = WL;
      if (m_pos == N) m_bonus = bonus_in;
      m_pos = np;
      if (np == 0 || np == WL) begin
        m_done = 1;
        if (np == 0) m_wr++; else m_wl++;
        if (m_wr == MW || m_wl == MW) begin m_over = 1; m_right = (np == 0); end
        else m_between = 1;
      end
    end else if (m_pos == N) begin
      m_bonus = bonus_in;
    end
  endtask

  task automatic compare_all();
    check("score", 32'(score), 32'(bar(m_pos)));
    check("wins_l", 32'(wins_l), 32'(m_wl));
    check("wins_r", 32'(wins_r), 32'(m_wr));
    check("round_done", 32'(round_done), 32'(m_done));
    check("match_over", 32'(match_over), 32'(m_over));
    if (m_over) check("match_right", 32'(match_right), 32'(m_right));
  endtask

  task automatic cycle(input bit r, input bit rt, input bit lo, input bit w,
                       input bit nr, input logic [BW-1:0] b);
    rst = r; right = rt; leds_on = lo; winrnd = w; next_round = nr; bonus_in = b;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle(input logic [BW-1:0] b);
    cycle(0, 0, 0, 0, 0, b);
  endtask

  initial begin
    rst = 1; right = 0; leds_on = 0; winrnd = 0; next_round = 0; bonus_in = '0;
    m_pos = N; m_bonus = '0; m_wl = 0; m_wr = 0;
    m_between = 0; m_over = 0; m_right = 0; m_done = 0;
    @(posedge clk); #1;

    // Reset state
    cycle(1, 0, 0, 0, 0, '0);
    check("rst_score", 32'(score), 32'h08);
    check("rst_over", 32'(match_over), 0);

    // Single steps: right proper push, then left jump
    cycle(0, 1, 1, 1, 0, '0);
    check("right_push", 32'(score), 32'h04);
    cycle(0, 0, 0, 1, 0, '0);
    check("left_jump", 32'(score), 32'h02);

    // Bonus latched at neutral, frozen once the rope leaves it
    cycle(1, 0, 0, 0, 0, '0);
    idle(7'b0001000);
    cycle(0, 1, 1, 1, 0, 7'b0001000);
    check("bonus_double", 32'(score), 32'h02);
    cycle(0, 0, 1, 1, 0, 7'b1111111);
`ifdef TOW_CATCHUP_EN
    check("bonus_frozen", 32'(score), 32'h08);
`else
    check("bonus_frozen", 32'(score), 32'h04);
`endif

    // Round win, ignored push, next round
    cycle(1, 0, 0, 0, 0, '0);
    repeat (4) cycle(0, 1, 1, 1, 0, '0);
    check("round_win_score", 32'(score), 32'h07);
    check("round_win_cnt", 32'(wins_r), 1);
    check("round_done_hi", 32'(round_done), 1);
    idle('0);
    check("round_done_lo", 32'(round_done), 0);
    cycle(0, 1, 1, 1, 0, '0);
    check("won_ignore_push", 32'(score), 32'h07);
    cycle(0, 0, 0, 0, 1, '0);
    check("next_round", 32'(score), 32'h08);

    // Match end, sticky result, reset clears
    repeat (4) cycle(0, 1, 1, 1, 0, '0);
    check("match_over", 32'(match_over), 1);
    check("match_right", 32'(match_right), 1);
    check("match_wins", 32'(wins_r), 2);
    cycle(0, 0, 0, 1, 1, '0);
    check("match_sticky", 32'(score), 32'h07);
    cycle(1, 0, 0, 0, 0, '0);
    check("match_rst_over", 32'(match_over), 0);
    check("match_rst_wins", 32'(wins_r), 0);

    // Catch-up from two positions onto the left side
    repeat (2) cycle(0, 0, 1, 1, 0, '0);
    check("catchup_setup", 32'(score), 32'h20);
    cycle(0, 1, 1, 1, 0, '0);
`ifdef TOW_CATCHUP_EN
    check("catchup_move", 32'(score), 32'h08);
`else
    check("catchup_move", 32'(score), 32'h10);
`endif

    // Randomised play
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) == 0), 1'($urandom), 1'($urandom_range(3) != 0),
            1'($urandom), ($urandom_range(3) == 0), BW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
